zbram_rd_arbiter: RTL
=====================

# zbram_rd_arbiter

Two-requester arbiter for the single read port of the pulse-counter BlockRAM. It lets the UART upload engine (requester A) and a second reader, such as a host or monitor path (requester B), share the port. Each side keeps the existing req/addr → data/done handshake, and neither requester needs to know the other exists. The block sits between both readers and the BlockRAM read port, driving the RAM enable and address and returning latched data.

## Interface
Parameters:
- ADDR_W, 12, read address width
- DATA_W, 16, read data width
- RD_LATENCY, 1, cycles from RAM enable/address to valid RAM data (1..4)

Ports:
- iClk  in  1  system clock; the only clock
- iRst  in  1  reset, synchronous, active-high
- iA_RdReq  in  1  requester A read request, level; held until oA_RdDone is seen
- iA_RdAddr  in  ADDR_W  requester A address, valid while iA_RdReq is high
- oA_RdData  out  DATA_W  read data for A, valid in the oA_RdDone cycle and held until A's next grant
- oA_RdDone  out  1  one-cycle completion pulse for A
- iB_RdReq, iB_RdAddr, oB_RdData, oB_RdDone  same as A, for requester B
- oBram_En  out  1  RAM read enable, one-cycle pulse
- oBram_Addr  out  ADDR_W  RAM read address
- iBram_Data  in  DATA_W  RAM read data
- oBusy  out  1  high in every state except IDLE
- oGrantB  out  1  owner of the current or last transaction: 0 = A, 1 = B

## Operation
- States: IDLE → ISSUE → WAIT → CAPTURE → DONE → IDLE.
- **IDLE**
  - Sample iA_RdReq and iB_RdReq at each edge.
  - Only one is high: grant that requester.
  - Both are high: grant the one not in last_grant (round-robin).
  - Granting latches the owner into last_grant/oGrantB and latches the owner's address into an internal register. Next state is ISSUE.
- **ISSUE** (1 cycle): oBram_En=1 and oBram_Addr=latched address.
- **WAIT**: RD_LATENCY-1 cycles with oBram_En=0. This state is skipped when RD_LATENCY=1.
- **CAPTURE**: iBram_Data is registered into the owner's oX_RdData only. The other requester's data register is untouched.
- **DONE** (1 cycle): the owner's oX_RdDone=1. Requests are NOT sampled in DONE. This gives a requester that clears its request on seeing done one cycle to drop it before IDLE samples again, so no duplicate read occurs.
- Address or request changes after the grant are ignored; the transaction uses the latched address.
- A request dropped before DONE still completes: the RAM is read, data is updated and done is pulsed.
- The non-owner's request simply waits. It is served on the next IDLE sample if still high.
- Fairness: under continuous contention, grants alternate strictly A, B, A, B.

## Timing
- Reset values: oBram_En=0, oBram_Addr=0, oA/oB_RdData=0, oA/oB_RdDone=0, oBusy=0, oGrantB=1 (last_grant=B, so A wins the first tie). State is IDLE.
- Latency: a request sampled at edge k gives oBram_En in cycle k+1 and done in cycle k+2+RD_LATENCY. This is 3 cycles for RD_LATENCY=1.
- Throughput: one read per 3+RD_LATENCY cycles.
- Done-to-next-grant for the same requester is at least 1 idle cycle.
- iRst high at any edge:
  - Aborts the transaction immediately; all outputs return to reset values on the next cycle.
  - No done pulse is emitted for the aborted read, and no stale done appears after reset.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package zbram_pkg:
  - requester ID constants (REQ_A=0, REQ_B=1)
  - state encoding constants
  - default ADDR_W/DATA_W
- Sub-module zrr_pick2: combinational two-way round-robin picker.
  - Inputs: reqA, reqB, last.
  - Outputs: valid, pick.
  - Reused by future arbiters on the same RAM's write port.

## Test plan
- **A only.** After reset, A requests addr 0x005 with RAM[5]=0x1987 and RD_LATENCY=1.
  - Response: oBram_En high one cycle with Addr 0x005, oA_RdDone high exactly 3 cycles after the request edge, oA_RdData=0x1987, oB_RdDone never high.
- **Simultaneous first request.** A (0x010) and B (0x020) raise requests in the same cycle after reset.
  - Response: A is served first and B second, back to back. oGrantB sequence is 0 then 1.
- **Continuous contention.** Both hold requests and re-request one cycle after each done, for 60 reads each from the upload loop pattern.
  - Response: strict A/B alternation, 120 dones total, with each data value matching RAM at its address.
- **Address change mid-transaction.** A changes its address from 0x003 to 0x7FF in the ISSUE cycle.
  - Response: RAM is read at 0x003 only, and oA_RdData=RAM[3].
- **Reset mid-operation.** Assert iRst in the WAIT state with RD_LATENCY=3.
  - Response: no done pulse, all outputs at reset values the next cycle, and a fresh A request then completes normally.
- **Sweep RD_LATENCY 1..4.** Run with a RAM model of matching latency.
  - Response: done arrives at k+2+RD_LATENCY, and data is correct for the addresses 0, 0xFFF and 0xBB7 (2999).

Source files
------------

// File: rtl/zbram_pkg.sv
// Shared definitions for the pulse-counter BlockRAM port arbiters.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package zbram_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;

    // Requester identities, also the encoding of last_grant / oGrantB
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } arbState_t;

endpackage

// File: rtl/zrr_pick2.sv
// Two-way round-robin picker: chooses between two level requests, favouring the one not served last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module zrr_pick2 (
    input  logic reqA,
    input  logic reqB,
    input  logic last,
    output logic valid,
    output logic pick
);

    // Lone requester wins outright; on a tie the side that did not go last wins
    always_comb begin
        valid = reqA | reqB;
        pick  = (reqA && reqB) ? ~last : reqB;
    end

endmodule

// File: rtl/zbram_rd_arbiter.sv
// Shares the single BlockRAM read port between requester A and requester B with round-robin arbitration.
// Latency: request sampled at edge k -> RAM enable in cycle k+1 -> done pulse in cycle k+2+RD_LATENCY.
// Backpressure: a losing requester keeps its level request high and is served on the next IDLE sample.
module zbram_rd_arbiter
    import zbram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
)(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iA_RdReq,
    input  logic [ADDR_W-1:0] iA_RdAddr,
    output logic [DATA_W-1:0] oA_RdData,
    output logic              oA_RdDone,
    input  logic              iB_RdReq,
    input  logic [ADDR_W-1:0] iB_RdAddr,
    output logic [DATA_W-1:0] oB_RdData,
    output logic              oB_RdDone,
    output logic              oBram_En,
    output logic [ADDR_W-1:0] oBram_Addr,
    input  logic [DATA_W-1:0] iBram_Data,
    output logic              oBusy,
    output logic              oGrantB
);

    // WAIT is held for RD_LATENCY-1 cycles, so the counter's last value is RD_LATENCY-2
    localparam int         WAIT_LAST   = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [1:0] WAIT_LAST_V = WAIT_LAST[1:0];

    arbState_t  state;
    arbState_t  stateNxt;
    logic       pickVld;
    logic       pickSel;
    logic       lastGrant;
    logic [1:0] waitCnt;
    logic       enNxt;
    logic       busyNxt;
    logic       doneANxt;
    logic       doneBNxt;

    zrr_pick2 uPick (
        .reqA  (iA_RdReq),
        .reqB  (iB_RdReq),
        .last  (lastGrant),
        .valid (pickVld),
        .pick  (pickSel)
    );

    assign oGrantB = lastGrant;

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= stateNxt;
    end

    // Next-state: requests are only looked at in IDLE, never in DONE
    always_comb begin
        stateNxt = state;
        unique case (state)
            ST_IDLE:    if (pickVld) stateNxt = ST_ISSUE;
            ST_ISSUE:   stateNxt = (RD_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT:    if (waitCnt == WAIT_LAST_V) stateNxt = ST_CAPTURE;
            ST_CAPTURE: stateNxt = ST_DONE;
            ST_DONE:    stateNxt = ST_IDLE;
            default:    stateNxt = ST_IDLE;
        endcase
    end

    // Output decode: values the output registers take on the coming edge
    always_comb begin
        enNxt    = (stateNxt == ST_ISSUE);
        busyNxt  = (stateNxt != ST_IDLE);
        doneANxt = (state == ST_CAPTURE) && (lastGrant == REQ_A);
        doneBNxt = (state == ST_CAPTURE) && (lastGrant == REQ_B);
    end

    // Registered outputs, owner/address latch and per-requester data capture
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oBram_En   <= 1'b0;
            oBram_Addr <= '0;
            oA_RdData  <= '0;
            oB_RdData  <= '0;
            oA_RdDone  <= 1'b0;
            oB_RdDone  <= 1'b0;
            oBusy      <= 1'b0;
            lastGrant  <= REQ_B;
        end else begin
            oBram_En  <= enNxt;
            oBusy     <= busyNxt;
            oA_RdDone <= doneANxt;
            oB_RdDone <= doneBNxt;
            if (state == ST_IDLE && pickVld) begin
                lastGrant  <= pickSel;
                oBram_Addr <= (pickSel == REQ_B) ? iB_RdAddr : iA_RdAddr;
            end
            if (doneANxt) oA_RdData <= iBram_Data;
            if (doneBNxt) oB_RdData <= iBram_Data;
        end
    end

    // Counts cycles spent in WAIT; parked at zero everywhere else
    always_ff @(posedge iClk) begin
        if (iRst || state != ST_WAIT) waitCnt <= '0;
        else                          waitCnt <= waitCnt + 2'd1;
    end

endmodule
